flags_stack_reg: RTL and testbench

- Next-generation CPU condition-flag register (Z/V/N), parametrised in flag width.
- Adds per-flag write masking and a hardware save/restore LIFO for interrupt entry and return.
- Sits between the ALU flag outputs and branch logic; the interrupt controller drives push/pop.
- Overflow and underflow of the save stack are detected and reported as sticky errors.

---
 rtl/flags_pkg.sv | 9 +
 rtl/flags_stack_reg_if.sv | 28 ++
 rtl/flags_lifo.sv | 62 ++++++
 rtl/flags_stack_reg.sv | 78 +++++++
 tb/tb_flags_stack_reg.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/flags_pkg.sv
// Shared definitions for the condition-flag register and its save stack.
package flags_pkg;
    localparam int FLAG_Z_BIT     = 2;
    localparam int FLAG_V_BIT     = 1;
    localparam int FLAG_N_BIT     = 0;
    localparam int FLAG_W_DEFAULT = 3;

    typedef logic [FLAG_W_DEFAULT-1:0] flags_t;
endpackage

// File: rtl/flags_stack_reg_if.sv
// Flag-register bus: ALU update, interrupt push/pop and status outputs.
interface flags_stack_reg_if #(
    parameter int FLAG_W = 3,
    parameter int CNT_W  = 3
);
    logic              en;
    logic [FLAG_W-1:0] wr_mask;
    logic [FLAG_W-1:0] d;
    logic              push;
    logic              pop;
    logic              err_clr;
    logic [FLAG_W-1:0] q;
    logic [CNT_W-1:0]  depth_cnt;
    logic              full;
    logic              empty;
    logic              ovf_err;
    logic              unf_err;

    modport master (
        output en, wr_mask, d, push, pop, err_clr,
        input  q, depth_cnt, full, empty, ovf_err, unf_err
    );

    modport slave (
        input  en, wr_mask, d, push, pop, err_clr,
        output q, depth_cnt, full, empty, ovf_err, unf_err
    );
endinterface

// File: rtl/flags_lifo.sv
// Save/restore LIFO for flag vectors; push, pop and in-place swap of the top.
module flags_lifo #(
    parameter int FLAG_W = 3,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [FLAG_W-1:0] din,
    output logic [FLAG_W-1:0] top,
    output logic [CNT_W-1:0]  cnt,
    output logic              full,
    output logic              empty
);
    import flags_pkg::*;

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [FLAG_W-1:0] mem_q [DEPTH];
    logic [FLAG_W-1:0] mem_d [DEPTH];
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic [CNT_W-1:0]  top_cnt;
    logic [AW-1:0]     top_idx;
    logic [AW-1:0]     wr_idx;

    assign full    = (cnt_q == CNT_W'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign top_cnt = cnt_q - 1'b1;
    assign top_idx = AW'(top_cnt);
    assign wr_idx  = AW'(cnt_q);
    assign top     = mem_q[top_idx];
    assign cnt     = cnt_q;

    always_comb begin
        mem_d = mem_q;
        cnt_d = cnt_q;
        // Swap rewrites the top in place; count is untouched.
        if (push && pop) begin
            if (!empty) mem_d[top_idx] = din;
        end else if (push) begin
            if (!full) begin
                mem_d[wr_idx] = din;
                cnt_d         = cnt_q + 1'b1;
            end
        end else if (pop) begin
            if (!empty) cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            cnt_q <= cnt_d;
            mem_q <= mem_d;
        end
    end
endmodule

// File: rtl/flags_stack_reg.sv
// Condition-flag register with masked ALU update, save stack and sticky errors.
module flags_stack_reg #(
    parameter int FLAG_W = 3,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 3
) (
    input logic              clk,
    input logic              rst,
    flags_stack_reg_if.slave bus
);
    import flags_pkg::*;

    logic [FLAG_W-1:0] q_q;
    logic [FLAG_W-1:0] q_d;
    logic [FLAG_W-1:0] m;
    logic [FLAG_W-1:0] upd;
    logic [FLAG_W-1:0] top;
    logic              ovf_q;
    logic              ovf_d;
    logic              unf_q;
    logic              unf_d;
    logic              full;
    logic              empty;
    logic              ovf_set;
    logic              unf_set;

    flags_lifo #(
        .FLAG_W (FLAG_W),
        .DEPTH  (DEPTH),
        .CNT_W  (CNT_W)
    ) u_lifo (
        .clk   (clk),
        .rst   (rst),
        .push  (bus.push),
        .pop   (bus.pop),
        .din   (q_q),
        .top   (top),
        .cnt   (bus.depth_cnt),
        .full  (full),
        .empty (empty)
    );

    assign m       = bus.en ? bus.wr_mask : '0;
    assign upd     = (q_q & ~m) | (bus.d & m);
    assign ovf_set = bus.push && !bus.pop && full;
    assign unf_set = bus.pop && !bus.push && empty;

    always_comb begin
        // A real pop (or swap) restores the saved top over any ALU update.
        q_d   = (bus.pop && !empty) ? top : upd;
        ovf_d = ovf_q;
        unf_d = unf_q;
        if (bus.err_clr) begin
            ovf_d = 1'b0;
            unf_d = 1'b0;
        end
        if (ovf_set) ovf_d = 1'b1;
        if (unf_set) unf_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q   <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            q_q   <= q_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign bus.q       = q_q;
    assign bus.full    = full;
    assign bus.empty   = empty;
    assign bus.ovf_err = ovf_q;
    assign bus.unf_err = unf_q;
endmodule

// File: tb/tb_flags_stack_reg.sv
// Directed bench for flags_stack_reg: mask, push/pop, overflow, underflow, swap.
module tb_flags_stack_reg;
    import flags_pkg::*;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    flags_stack_reg_if #(.FLAG_W(3), .CNT_W(3)) bus ();

    flags_stack_reg #(.FLAG_W(3), .DEPTH(4), .CNT_W(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.en = 0; bus.wr_mask = '0; bus.d = '0;
        bus.push = 0; bus.pop = 0; bus.err_clr = 0;
    endtask

    task automatic load(input logic [2:0] v);
        idle();
        bus.en = 1; bus.wr_mask = 3'b111; bus.d = v;
        step();
        idle();
    endtask

    task automatic test_reset();
        idle();
        rst = 1;
        #2;
        checks++;
        if (bus.q !== 3'b000 || bus.depth_cnt !== 3'd0 || bus.empty !== 1'b1
            || bus.full !== 1'b0 || bus.ovf_err !== 1'b0 || bus.unf_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_init q=%b cnt=%0d e=%b f=%b o=%b u=%b want 000 0 1 0 0 0",
                     bus.q, bus.depth_cnt, bus.empty, bus.full, bus.ovf_err, bus.unf_err);
        end
        step();
        rst = 0;
        step();
        // build up two entries and a nonzero q, then reset between edges
        load(3'b101);
        bus.push = 1; step();
        bus.push = 1; step();
        idle();
        checks++;
        if (bus.depth_cnt !== 3'd2) begin
            errors++;
            $display("FAIL reset_pre cnt=%0d want 2", bus.depth_cnt);
        end
        #2 rst = 1;
        #1;
        checks++;
        if (bus.q !== 3'b000 || bus.depth_cnt !== 3'd0 || bus.empty !== 1'b1
            || bus.ovf_err !== 1'b0 || bus.unf_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid q=%b cnt=%0d e=%b o=%b u=%b want 000 0 1 0 0",
                     bus.q, bus.depth_cnt, bus.empty, bus.ovf_err, bus.unf_err);
        end
        step();
        rst = 0;
        step();
    endtask

    task automatic test_mask();
        idle();
        bus.en = 1; bus.wr_mask = 3'b100; bus.d = 3'b111;
        step();
        checks++;
        if (bus.q !== 3'b100) begin
            errors++; $display("FAIL mask_z q=%b want 100", bus.q);
        end
        bus.wr_mask = 3'b011; bus.d = 3'b011;
        step();
        checks++;
        if (bus.q !== 3'b111) begin
            errors++; $display("FAIL mask_vn q=%b want 111", bus.q);
        end
        bus.en = 0; bus.wr_mask = 3'b111; bus.d = 3'b000;
        step();
        checks++;
        if (bus.q !== 3'b111) begin
            errors++; $display("FAIL mask_hold q=%b want 111", bus.q);
        end
        bus.en = 1; bus.wr_mask = 3'b000; bus.d = 3'b000;
        step();
        checks++;
        if (bus.q !== 3'b111) begin
            errors++; $display("FAIL mask_zero q=%b want 111", bus.q);
        end
        idle();
    endtask

    task automatic test_push_pop();
        load(3'b101);
        bus.push = 1; bus.en = 1; bus.d = 3'b010; bus.wr_mask = 3'b111;
        step();
        idle();
        checks++;
        if (bus.q !== 3'b010 || bus.depth_cnt !== 3'd1 || bus.empty !== 1'b0) begin
            errors++;
            $display("FAIL push_upd q=%b cnt=%0d e=%b want 010 1 0", bus.q, bus.depth_cnt, bus.empty);
        end
        bus.pop = 1; bus.en = 1; bus.d = 3'b111; bus.wr_mask = 3'b111;
        step();
        idle();
        checks++;
        if (bus.q !== 3'b101 || bus.empty !== 1'b1 || bus.unf_err !== 1'b0) begin
            errors++;
            $display("FAIL pop_restore q=%b e=%b u=%b want 101 1 0", bus.q, bus.empty, bus.unf_err);
        end
    endtask

    task automatic test_overflow();
        logic [2:0] exp_q [4];
        exp_q[0] = 3'b100; exp_q[1] = 3'b011; exp_q[2] = 3'b010; exp_q[3] = 3'b001;
        for (int k = 1; k <= 4; k++) begin
            load(3'(k));
            bus.push = 1; step(); idle();
            if (k == 3) begin
                checks++;
                if (bus.full !== 1'b0 || bus.depth_cnt !== 3'd3) begin
                    errors++;
                    $display("FAIL ovf_three f=%b cnt=%0d want 0 3", bus.full, bus.depth_cnt);
                end
            end
        end
        checks++;
        if (bus.full !== 1'b1 || bus.depth_cnt !== 3'd4 || bus.ovf_err !== 1'b0) begin
            errors++;
            $display("FAIL ovf_full f=%b cnt=%0d o=%b want 1 4 0", bus.full, bus.depth_cnt, bus.ovf_err);
        end
        bus.push = 1; bus.en = 1; bus.d = 3'b111; bus.wr_mask = 3'b111;
        step(); idle();
        checks++;
        if (bus.ovf_err !== 1'b1 || bus.depth_cnt !== 3'd4 || bus.q !== 3'b111) begin
            errors++;
            $display("FAIL ovf_set o=%b cnt=%0d q=%b want 1 4 111", bus.ovf_err, bus.depth_cnt, bus.q);
        end
        for (int k = 0; k < 4; k++) begin
            bus.pop = 1; step(); idle();
            checks++;
            if (bus.q !== exp_q[k]) begin
                errors++;
                $display("FAIL ovf_pop%0d q=%b want %b", k, bus.q, exp_q[k]);
            end
        end
        checks++;
        if (bus.empty !== 1'b1 || bus.ovf_err !== 1'b1) begin
            errors++;
            $display("FAIL ovf_sticky e=%b o=%b want 1 1", bus.empty, bus.ovf_err);
        end
        bus.err_clr = 1; step(); idle();
        checks++;
        if (bus.ovf_err !== 1'b0) begin
            errors++; $display("FAIL ovf_clr o=%b want 0", bus.ovf_err);
        end
    endtask

    task automatic test_underflow();
        bus.pop = 1; bus.en = 1; bus.d = 3'b110; bus.wr_mask = 3'b111;
        step(); idle();
        checks++;
        if (bus.unf_err !== 1'b1 || bus.q !== 3'b110 || bus.depth_cnt !== 3'd0) begin
            errors++;
            $display("FAIL unf_set u=%b q=%b cnt=%0d want 1 110 0", bus.unf_err, bus.q, bus.depth_cnt);
        end
        bus.err_clr = 1; step(); idle();
        checks++;
        if (bus.unf_err !== 1'b0) begin
            errors++; $display("FAIL unf_clr u=%b want 0", bus.unf_err);
        end
        bus.err_clr = 1; bus.pop = 1; step(); idle();
        checks++;
        if (bus.unf_err !== 1'b1) begin
            errors++; $display("FAIL unf_set_wins u=%b want 1", bus.unf_err);
        end
        bus.err_clr = 1; step(); idle();
    endtask

    task automatic test_swap();
        load(3'b011);
        bus.push = 1; step(); idle();
        load(3'b101);
        bus.push = 1; bus.pop = 1; step(); idle();
        checks++;
        if (bus.q !== 3'b011 || bus.depth_cnt !== 3'd1 || bus.ovf_err !== 1'b0
            || bus.unf_err !== 1'b0) begin
            errors++;
            $display("FAIL swap q=%b cnt=%0d o=%b u=%b want 011 1 0 0",
                     bus.q, bus.depth_cnt, bus.ovf_err, bus.unf_err);
        end
        bus.pop = 1; step(); idle();
        checks++;
        if (bus.q !== 3'b101 || bus.empty !== 1'b1) begin
            errors++;
            $display("FAIL swap_top q=%b e=%b want 101 1", bus.q, bus.empty);
        end
        bus.push = 1; bus.pop = 1; step(); idle();
        checks++;
        if (bus.q !== 3'b101 || bus.depth_cnt !== 3'd0 || bus.ovf_err !== 1'b0
            || bus.unf_err !== 1'b0) begin
            errors++;
            $display("FAIL swap_empty q=%b cnt=%0d o=%b u=%b want 101 0 0 0",
                     bus.q, bus.depth_cnt, bus.ovf_err, bus.unf_err);
        end
        bus.push = 1; bus.pop = 1; bus.en = 1; bus.d = 3'b010; bus.wr_mask = 3'b110;
        step(); idle();
        checks++;
        if (bus.q !== 3'b011 || bus.depth_cnt !== 3'd0) begin
            errors++;
            $display("FAIL swap_empty_upd q=%b cnt=%0d want 011 0", bus.q, bus.depth_cnt);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst    = 1;
        idle();
        test_reset();
        test_mask();
        test_push_pop();
        test_overflow();
        test_underflow();
        test_swap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
